// File: rtl/cd4073_bist_ctrl.sv
// BIST sequencer for the cd4073 triple 3-input AND: sweeps all 512 input vectors, checks y1..y3.
// Optional macro CD4073_BIST_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module cd4073_bist_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             y1,
   input  logic             y2,
   input  logic             y3,
   output logic [2:0]       a1,
   output logic [2:0]       a2,
   output logic [2:0]       a3,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [2:0]       fail_mask,
   output logic [8:0]       first_fail_vec,
   output logic             first_fail_valid
);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   localparam logic [3:0]       RELOAD  = 4'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   state_t     state;
   logic [8:0] vec;
   logic [3:0] cnt;
   logic [2:0] mism;

   // Gate inputs come straight from the vector register, never from start.
   assign a1 = vec[8:6];
   assign a2 = vec[5:3];
   assign a3 = vec[2:0];

   assign mism = {y3 ^ (&vec[2:0]), y2 ^ (&vec[5:3]), y1 ^ (&vec[8:6])};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         vec              <= '0;
         cnt              <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         fail_mask        <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  vec              <= '0;
                  cnt              <= RELOAD;
                  busy             <= 1'b1;
                  pass             <= 1'b0;
                  err_count        <= '0;
                  fail_mask        <= '0;
                  first_fail_vec   <= '0;
                  first_fail_valid <= 1'b0;
                  state            <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == 4'd0) state <= CHECK;
               else             cnt   <= cnt - 4'd1;
            end
            CHECK: begin
               if (mism != 3'b000) begin
                  if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                  fail_mask <= fail_mask | mism;
                  if (!first_fail_valid) begin
                     first_fail_vec   <= vec;
                     first_fail_valid <= 1'b1;
                  end
               end
`ifdef CD4073_BIST_STOP_ON_FAIL_EN
               if (mism != 3'b000 || vec == 9'd511) begin
`else
               if (vec == 9'd511) begin
`endif
                  state <= DONE;
               end else begin
                  vec   <= vec + 9'd1;
                  cnt   <= RELOAD;
                  state <= SETTLE;
               end
            end
            DONE: begin
               // err_count already includes the final CHECK here.
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (err_count == '0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cd4073_bist_ctrl.sv
// Bench for cd4073_bist_ctrl: cd4073 model with injectable stuck-at faults and a scoreboard
// that checks each sweep's results when done pulses.
module tb_cd4073_bist_ctrl;

   localparam int ERR_W = 10;
   localparam int W     = 36;   // {lat[11:0], pass, err[9:0], mask[2:0], ffv[8:0], ffvalid}

   logic             clk;
   logic             rst;
   logic             start;
   logic             y1, y2, y3;
   logic [2:0]       a1, a2, a3;
   logic             busy, done, pass;
   logic [ERR_W-1:0] err_count;
   logic [2:0]       fail_mask;
   logic [8:0]       first_fail_vec;
   logic             first_fail_valid;

   cd4073_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .y1(y1), .y2(y2), .y3(y3),
      .a1(a1), .a2(a2), .a3(a3),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_mask(fail_mask),
      .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
   );

   // 0 none, 1 y2 stuck-at-1, 2 y3 stuck-at-0, 3 y1 stuck-at-0
   int fault;
   always_comb begin
      y1 = &a1;
      y2 = &a2;
      y3 = &a3;
      if (fault == 1) y2 = 1'b1;
      if (fault == 2) y3 = 1'b0;
      if (fault == 3) y1 = 1'b0;
   end

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int start_cyc = 0;
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] mk(int lat, logic p, int err, logic [2:0] mask,
                                       int ffv, logic ffvalid);
      return {12'(lat), p, 10'(err), mask, 9'(ffv), ffvalid};
   endfunction

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            chk("done_latency", cyc - start_cyc, e[35:24]);
            chk("pass", pass, e[23]);
            chk("err_count", err_count, e[22:13]);
            chk("fail_mask", fail_mask, e[12:10]);
            chk("first_fail_valid", first_fail_valid, e[0]);
            if (e[0]) chk("first_fail_vec", first_fail_vec, e[9:1]);
            chk("busy_at_done", busy, 0);
         end
      end
   end

   // driver: run one sweep; optional re-pulse of start at relative cycle repulse_at
   task automatic run_sweep(input int fault_sel, input int repulse_at, input logic [W-1:0] exp_word);
      int  seen;
      bit  got;
      fault = fault_sel;
      exp_q.push_back(exp_word);
      @(negedge clk);
      start = 1'b1;
      seen  = done_cnt;
      got   = 1'b0;
      for (int i = 0; i < 2100; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start_cyc = cyc;
            chk("busy_after_start", busy, 1);
         end
         start = (i == repulse_at);
         if (i == 1536 && done_cnt == seen) chk("busy_last_check", busy, 1);
         if (done_cnt != seen) begin
            got = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within 2100 cycles");
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int d0;
      fault = 0;
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {a1, a2, a3, busy, done, pass, err_count, fail_mask,
                            first_fail_vec, first_fail_valid}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

`ifdef CD4073_BIST_STOP_ON_FAIL_EN
      run_sweep(0, -1, mk(1537, 1, 0, 3'b000, 0, 0));
      run_sweep(2, -1, mk(25, 0, 1, 3'b100, 7, 1));
      chk("a3_frozen", a3, 7);
`else
      run_sweep(0, -1, mk(1537, 1, 0, 3'b000, 0, 0));
      chk("a_after_sweep", {a1, a2, a3}, 511);
      run_sweep(1, -1, mk(1537, 0, 448, 3'b010, 0, 1));
      run_sweep(2, -1, mk(1537, 0, 64, 3'b100, 7, 1));
      repeat (10) @(negedge clk);
      chk("retain_err_count", err_count, 64);
      chk("retain_pass", pass, 0);
      run_sweep(3, -1, mk(1537, 0, 64, 3'b001, 448, 1));
      // start re-pulsed while vector 100 is settling
      run_sweep(0, 301, mk(1537, 1, 0, 3'b000, 0, 0));

      // abort during SETTLE of vector 200
      fault = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i <= 600; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("mid_vec_200", {a1, a2, a3}, 200);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("abort_outputs", {a1, a2, a3, busy, done, pass, err_count, fail_mask,
                            first_fail_vec, first_fail_valid}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      chk("no_done_after_abort", done_cnt, d0);
      run_sweep(0, -1, mk(1537, 1, 0, 3'b000, 0, 0));
`endif

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cd4073_bist_ctrl.md
Name: cd4073_bist_ctrl

Overview:
Built-in self-test sequencer for the cd4073 triple 3-input AND model. On a start pulse it sweeps all 512 combinations of the three 3-bit gate inputs, waits a settle time per vector, and samples y1..y3. It compares each sample against the expected AND result and reports an error count, a failing-gate mask and the first failing vector. It sits between a test host (or UART command decoder) and a cd4073 instance, and owns that instance's inputs during a run.

Parameters:
SETTLE_CYCLES, 2, clock cycles each vector is held before y is sampled (legal range 1..15)
ERR_W, 10, width of err_count (must be >= 10 so 512 holds without saturation)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle run request, sampled only in IDLE
y1  input  1  cd4073 gate 1 output
y2  input  1  cd4073 gate 2 output
y3  input  1  cd4073 gate 3 output
a1  output  3  cd4073 gate 1 inputs, registered
a2  output  3  cd4073 gate 2 inputs, registered
a3  output  3  cd4073 gate 3 inputs, registered
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep ends
pass  output  1  high if the last completed sweep had err_count == 0
err_count  output  ERR_W  number of failing vectors in the current or last sweep
fail_mask  output  3  sticky OR of failing gates; bit0 = y1, bit1 = y2, bit2 = y3
first_fail_vec  output  9  vector index of the first mismatch
first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all outputs 0; state = IDLE; internal vec = 0; settle counter = 0.
- Vector mapping: 9-bit vec; a1 = vec[8:6], a2 = vec[5:3], a3 = vec[2:0]. The a outputs are driven from registers only, with no combinational path from start.
- Expected response: exp1 = &a1, exp2 = &a2, exp3 = &a3.
- IDLE:
  - The a outputs hold their last value; busy = 0.
  - If start = 1 at an edge: vec <= 0; err_count, fail_mask, first_fail_valid and pass cleared; settle counter <= SETTLE_CYCLES-1; go to SETTLE. busy = 1 from this edge.
- SETTLE:
  - The a outputs reflect vec.
  - The counter decrements each cycle; when it is 0, go to CHECK.
  - The vector is therefore held for exactly SETTLE_CYCLES cycles before CHECK.
- CHECK (one cycle):
  - Sample y, form mism = {y3^exp3, y2^exp2, y1^exp1}.
  - If mism != 0:
    - err_count increments by 1 (one per vector, regardless of how many gates fail), saturating at all-ones.
    - fail_mask |= mism.
    - If first_fail_valid = 0: capture vec into first_fail_vec and set first_fail_valid.
  - If vec == 511: go to DONE. Otherwise vec <= vec+1, reload the counter, go to SETTLE.
- DONE (one cycle): done = 1, busy = 0, pass <= (err_count == 0 after the final CHECK); return to IDLE.
- Latency: with the start edge as edge 0, each vector costs SETTLE_CYCLES+1 cycles. done is high in the cycle after edge 512*(SETTLE_CYCLES+1)+1; for SETTLE_CYCLES = 2 that is edge 1537.
- Result retention: results hold until the next accepted start.
- start outside IDLE (including during DONE) is ignored, with no effect on the run.
- rst asserted mid-sweep: immediate abort to reset values; done is not pulsed.

Optional Feature:
Macro CD4073_BIST_STOP_ON_FAIL_EN.
- Defined: the first CHECK with mism != 0 goes directly to DONE after updating the results. err_count = 1, pass = 0, and the a outputs freeze on the failing vector.
- Not defined: the full 512-vector sweep always completes.

Test Plan:
- Fault-free cd4073, SETTLE_CYCLES = 2, start pulse at edge 0 -> busy high edges 1..1536; done pulse after edge 1537; err_count = 0, pass = 1, fail_mask = 000, first_fail_valid = 0.
- y2 forced stuck-at-1 -> err_count = 448, fail_mask = 010, first_fail_vec = 0, pass = 0.
- y3 forced stuck-at-0 -> err_count = 64, fail_mask = 100, first_fail_vec = 7, pass = 0.
- start re-pulsed at vector 100 mid-run -> ignored; done at the same cycle as the fault-free run; results identical to the fault-free run.
- rst asserted during SETTLE of vector 200 -> all outputs 0 in the same cycle; no done pulse; a following start performs a full clean sweep.
- CD4073_BIST_STOP_ON_FAIL_EN defined, y3 stuck-at-0 -> done pulse following the vector-7 CHECK; err_count = 1, a3 = 111 held, first_fail_vec = 7.
